// File: rtl/cache_victim_buf_pkg.sv
// Shared types and size derivations for the dirty-victim writeback buffer.
// The buffer's optional snoop comparators are enabled with VICTIMBUF_SNOOP_EN.
package cachevictimbuf_pkg;

  // Default geometry. The top module's parameters start from these values.
  localparam int NUMWAYS_DEF   = 4;
  localparam int SETLEN_DEF    = 9;
  localparam int OFFSETLEN_DEF = 5;
  localparam int TAGLEN_DEF    = 20;
  localparam int LINELEN_DEF   = 256;
  localparam int BEATLEN_DEF   = 64;
  localparam int DEPTH_DEF     = 2;

  // Number of bus beats needed to move one line.
  function automatic int beats_of(input int linelen, input int beatlen);
    return linelen / beatlen;
  endfunction

  // Width of the beat counter that walks through one line.
  function automatic int beatidx_of(input int linelen, input int beatlen);
    return $clog2(linelen / beatlen);
  endfunction

  // Buffered victim at the default geometry. Packages cannot take parameters,
  // so the top module declares an identically shaped struct sized from its own
  // parameters.
  typedef struct packed {
    logic [TAGLEN_DEF-1:0]  tag;
    logic [SETLEN_DEF-1:0]  set;
    logic [LINELEN_DEF-1:0] line;
  } entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } drain_state_t;

endpackage

// File: rtl/cache_victim_buf_mux.sv
// One-hot AND-OR way selector: picks the victim way's tag and line from the
// flattened per-way read buses (way 0 in the LSBs).
module cachevictimmux #(
  parameter int NUMWAYS = 4,
  parameter int TAGLEN  = 20,
  parameter int LINELEN = 256
) (
  input  logic [NUMWAYS-1:0]         VictimWay,
  input  logic [NUMWAYS*TAGLEN-1:0]  ReadTagWay,
  input  logic [NUMWAYS*LINELEN-1:0] ReadDataLineWay,
  output logic [TAGLEN-1:0]          VictimTag,
  output logic [LINELEN-1:0]         VictimLine
);

  // Running OR chains; each stage folds in one way gated by its select bit.
  logic [TAGLEN-1:0]  tag_acc  [NUMWAYS+1];
  logic [LINELEN-1:0] line_acc [NUMWAYS+1];

  assign tag_acc[0]  = '0;
  assign line_acc[0] = '0;

  for (genvar gi = 0; gi < NUMWAYS; gi++) begin : g_way
    assign tag_acc[gi+1]  = tag_acc[gi]
                          | (ReadTagWay[gi*TAGLEN +: TAGLEN] & {TAGLEN{VictimWay[gi]}});
    assign line_acc[gi+1] = line_acc[gi]
                          | (ReadDataLineWay[gi*LINELEN +: LINELEN] & {LINELEN{VictimWay[gi]}});
  end

  assign VictimTag  = tag_acc[NUMWAYS];
  assign VictimLine = line_acc[NUMWAYS];

endmodule

// File: rtl/cache_victim_buf.sv
// Dirty-victim writeback buffer: captures evicted dirty lines into a small
// FIFO and drains each one to the bus as a burst of beats.
// Optional feature macro: VICTIMBUF_SNOOP_EN (exact per-entry address snoop;
// without it Conflict is simply "buffer not empty").
module cache_victim_buf
  import cachevictimbuf_pkg::*;
#(
  parameter int NUMWAYS   = NUMWAYS_DEF,
  parameter int SETLEN    = SETLEN_DEF,
  parameter int OFFSETLEN = OFFSETLEN_DEF,
  parameter int TAGLEN    = TAGLEN_DEF,
  parameter int LINELEN   = LINELEN_DEF,
  parameter int BEATLEN   = BEATLEN_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            FlushStage,
  input  logic                            CaptureReq,
  input  logic [NUMWAYS-1:0]              VictimWay,
  input  logic [NUMWAYS-1:0]              DirtyWay,
  input  logic [NUMWAYS*TAGLEN-1:0]       ReadTagWay,
  input  logic [NUMWAYS*LINELEN-1:0]      ReadDataLineWay,
  input  logic [SETLEN-1:0]               CacheSet,
  output logic                            CaptureStall,
  output logic                            WBValid,
  input  logic                            WBReady,
  output logic [TAGLEN+SETLEN+OFFSETLEN-1:0] WBAdr,
  output logic [BEATLEN-1:0]              WBData,
  output logic                            WBLast,
  input  logic [TAGLEN+SETLEN-1:0]        LookupAdr,
  output logic                            Conflict,
  output logic                            Empty
);

  localparam int BEATS      = beats_of(LINELEN, BEATLEN);
  localparam int BEATIDXLEN = beatidx_of(LINELEN, BEATLEN);
  localparam int PTRLEN     = $clog2(DEPTH);

  typedef struct packed {
    logic [TAGLEN-1:0]  tag;
    logic [SETLEN-1:0]  set;
    logic [LINELEN-1:0] line;
  } buf_entry_t;

  logic [TAGLEN-1:0]     victim_tag;
  logic [LINELEN-1:0]    victim_line;
  logic                  victim_dirty;
  logic                  capture_ok;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  last_beat;
  logic                  more_after_pop;
  logic [PTRLEN:0]       wr_ptr;
  logic [PTRLEN:0]       rd_ptr;
  logic [PTRLEN:0]       count;
  logic [BEATIDXLEN-1:0] beat_cnt;
  drain_state_t          state;
  buf_entry_t            mem [DEPTH];
  buf_entry_t            head;
  logic [BEATLEN-1:0]    beat_words [BEATS];

  cachevictimmux #(
    .NUMWAYS (NUMWAYS),
    .TAGLEN  (TAGLEN),
    .LINELEN (LINELEN)
  ) u_mux (
    .VictimWay       (VictimWay),
    .ReadTagWay      (ReadTagWay),
    .ReadDataLineWay (ReadDataLineWay),
    .VictimTag       (victim_tag),
    .VictimLine      (victim_line)
  );

  // Occupancy: the extra pointer bit separates full from empty.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTRLEN] != rd_ptr[PTRLEN]) &&
                 (wr_ptr[PTRLEN-1:0] == rd_ptr[PTRLEN-1:0]);
  assign Empty = empty;

  // Only dirty, unsquashed evictions need a writeback; full always blocks,
  // even if the head entry retires in the same cycle.
  assign victim_dirty = |(VictimWay & DirtyWay);
  assign capture_ok   = CaptureReq & ~FlushStage & victim_dirty;
  assign push         = capture_ok & ~full;
  assign CaptureStall = capture_ok & full;

  assign last_beat      = (beat_cnt == BEATIDXLEN'(BEATS - 1));
  assign pop            = WBValid & WBReady & last_beat;
  assign more_after_pop = push || (count > (PTRLEN+1)'(1));

  // Head entry sliced into beats; address carries the beat index above the
  // byte offset bits within a beat.
  assign head = mem[rd_ptr[PTRLEN-1:0]];
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    assign beat_words[gi] = head.line[gi*BEATLEN +: BEATLEN];
  end
  assign WBData = beat_words[beat_cnt];
  assign WBAdr  = {head.tag, head.set, beat_cnt, {(OFFSETLEN-BEATIDXLEN){1'b0}}};
  assign WBLast = WBValid & last_beat;

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTRLEN-1:0]] <= '{tag: victim_tag, set: CacheSet, line: victim_line};
    end
  end

  // FIFO pointers; wrap comes for free from the pointer width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Drain FSM: present the head entry beat by beat, holding on backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      WBValid  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          beat_cnt <= '0;
          if (!empty) begin
            state   <= ST_SEND;
            WBValid <= 1'b1;
          end
        end
        default: begin
          if (WBReady) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat && !more_after_pop) begin
              state   <= ST_IDLE;
              WBValid <= 1'b0;
            end
          end
        end
      endcase
    end
  end

`ifdef VICTIMBUF_SNOOP_EN
  // Exact snoop: compare every occupied slot, including the one draining.
  logic [DEPTH-1:0] hit;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_snoop
    logic [PTRLEN-1:0] off;
    assign off     = PTRLEN'(gi) - rd_ptr[PTRLEN-1:0];
    assign hit[gi] = ({1'b0, off} < count) && ({mem[gi].tag, mem[gi].set} == LookupAdr);
  end
  assign Conflict = |hit;
`else
  // Conservative: any buffered line might be the one being refilled.
  logic unused_lookup;
  assign unused_lookup = ^LookupAdr;
  assign Conflict      = ~empty;
`endif

endmodule

// File: tb/tb_cache_victim_buf.sv
// Self-checking bench for cache_victim_buf: expected beats are queued when a
// capture is driven and compared as the bus accepts them.
module tb_cache_victim_buf;

  localparam int NW = 4, SL = 9, OL = 5, TL = 20, LL = 256, BL = 64, DP = 2;
  localparam int AW = TL + SL + OL;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               FlushStage = 1'b0;
  logic               CaptureReq = 1'b0;
  logic [NW-1:0]      VictimWay = '0;
  logic [NW-1:0]      DirtyWay = '0;
  logic [NW*TL-1:0]   ReadTagWay = '0;
  logic [NW*LL-1:0]   ReadDataLineWay = '0;
  logic [SL-1:0]      CacheSet = '0;
  logic               CaptureStall;
  logic               WBValid;
  logic               WBReady = 1'b0;
  logic [AW-1:0]      WBAdr;
  logic [BL-1:0]      WBData;
  logic               WBLast;
  logic [TL+SL-1:0]   LookupAdr = '0;
  logic               Conflict;
  logic               Empty;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [BL-1:0] data;
    logic          last;
  } beat_t;

  beat_t          sb[$];
  beat_t          mon_exp;
  int             pass_cnt = 0;
  int             total_cnt = 0;
  int             accepted = 0;
  logic           hold_pending = 1'b0;
  logic [AW-1:0]  hold_adr;
  logic [BL-1:0]  hold_data;

  cache_victim_buf #(
    .NUMWAYS(NW), .SETLEN(SL), .OFFSETLEN(OL), .TAGLEN(TL),
    .LINELEN(LL), .BEATLEN(BL), .DEPTH(DP)
  ) dut (
    .clk(clk), .reset(reset), .FlushStage(FlushStage), .CaptureReq(CaptureReq),
    .VictimWay(VictimWay), .DirtyWay(DirtyWay), .ReadTagWay(ReadTagWay),
    .ReadDataLineWay(ReadDataLineWay), .CacheSet(CacheSet),
    .CaptureStall(CaptureStall), .WBValid(WBValid), .WBReady(WBReady),
    .WBAdr(WBAdr), .WBData(WBData), .WBLast(WBLast), .LookupAdr(LookupAdr),
    .Conflict(Conflict), .Empty(Empty)
  );

  always #5 clk = ~clk;

  // Bus monitor: scoreboard compare on every accepted beat, hold check under backpressure
  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        total_cnt++;
        if (WBValid !== 1'b1 || WBAdr !== hold_adr || WBData !== hold_data)
          $display("FAIL hold_stable: valid=%b adr=%h data=%h, required valid=1 adr=%h data=%h",
                   WBValid, WBAdr, WBData, hold_adr, hold_data);
        else pass_cnt++;
      end
      if (WBValid && WBReady) begin
        accepted++;
        total_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL beat_unexpected: adr=%h data=%h last=%b, required no beat", WBAdr, WBData, WBLast);
        end else begin
          mon_exp = sb.pop_front();
          if (WBAdr !== mon_exp.adr || WBData !== mon_exp.data || WBLast !== mon_exp.last)
            $display("FAIL beat: adr=%h data=%h last=%b, required adr=%h data=%h last=%b",
                     WBAdr, WBData, WBLast, mon_exp.adr, mon_exp.data, mon_exp.last);
          else begin
            pass_cnt++;
            $display("beat adr=%h data=%h last=%b ok", WBAdr, WBData, WBLast);
          end
        end
      end
      hold_pending = WBValid && !WBReady;
      hold_adr     = WBAdr;
      hold_data    = WBData;
    end
  end

  // Fill all ways with random tags/lines, then place the victim's tag; other
  // ways get random dirty bits so the AND with VictimWay matters.
  task automatic set_victim(input int way, input logic [TL-1:0] tag, input logic [SL-1:0] set,
                            input logic dirty, output logic [LL-1:0] line);
    logic [NW-1:0] others;
    for (int w = 0; w < NW; w++) begin
      ReadTagWay[w*TL +: TL] = TL'($urandom);
      for (int k = 0; k < LL/32; k++) ReadDataLineWay[w*LL + k*32 +: 32] = $urandom;
    end
    ReadTagWay[way*TL +: TL] = tag;
    line      = ReadDataLineWay[way*LL +: LL];
    VictimWay = NW'(1) << way;
    others    = NW'($urandom) & ~VictimWay;
    DirtyWay  = others | (dirty ? VictimWay : '0);
    CacheSet  = set;
  endtask

  task automatic push_expected(input logic [TL-1:0] tag, input logic [SL-1:0] set,
                               input logic [LL-1:0] line);
    beat_t b;
    for (int i = 0; i < LL/BL; i++) begin
      b.adr  = {tag, set, 2'(i), 3'b000};
      b.data = line[i*BL +: BL];
      b.last = (i == LL/BL - 1);
      sb.push_back(b);
    end
  endtask

  task automatic do_capture(input int way, input logic [TL-1:0] tag, input logic [SL-1:0] set);
    logic [LL-1:0] line;
    set_victim(way, tag, set, 1'b1, line);
    CaptureReq = 1'b1;
    @(posedge clk);
    push_expected(tag, set, line);
    #1 CaptureReq = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    total_cnt++; if (WBValid !== 1'b0) $display("FAIL reset_wbvalid: got %b want 0", WBValid); else pass_cnt++;
    total_cnt++; if (WBLast !== 1'b0) $display("FAIL reset_wblast: got %b want 0", WBLast); else pass_cnt++;
    total_cnt++; if (Empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", Empty); else pass_cnt++;
    total_cnt++; if (Conflict !== 1'b0) $display("FAIL reset_conflict: got %b want 0", Conflict); else pass_cnt++;
    total_cnt++; if (CaptureStall !== 1'b0) $display("FAIL reset_stall: got %b want 0", CaptureStall); else pass_cnt++;
  endtask

  task automatic test_dirty_capture;
    logic [LL-1:0] line;
    @(posedge clk); #1;
    WBReady = 1'b1;
    set_victim(2, 20'h12345, 9'h01A, 1'b1, line);
    CaptureReq = 1'b1;
    #1;
    total_cnt++; if (CaptureStall !== 1'b0) $display("FAIL dirty_stall: got %b want 0", CaptureStall); else pass_cnt++;
    @(posedge clk);
    push_expected(20'h12345, 9'h01A, line);
    #1 CaptureReq = 1'b0;
    total_cnt++; if (Empty !== 1'b0) $display("FAIL dirty_empty_fall: got %b want 0", Empty); else pass_cnt++;
    total_cnt++; if (WBValid !== 1'b0) $display("FAIL dirty_valid_latency: got %b want 0", WBValid); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (WBValid !== 1'b1) $display("FAIL dirty_valid_rise: got %b want 1", WBValid); else pass_cnt++;
    wait_drain(30);
    total_cnt++; if (sb.size() != 0) $display("FAIL dirty_drain: %0d beats left, want 0", sb.size()); else pass_cnt++;
    total_cnt++; if (Empty !== 1'b1) $display("FAIL dirty_empty_after: got %b want 1", Empty); else pass_cnt++;
    total_cnt++; if (WBValid !== 1'b0) $display("FAIL dirty_idle_after: got %b want 0", WBValid); else pass_cnt++;
  endtask

  task automatic test_clean_victim;
    logic [LL-1:0] line;
    set_victim(1, 20'h0BEEF, 9'h033, 1'b0, line);
    CaptureReq = 1'b1;
    #1;
    total_cnt++; if (CaptureStall !== 1'b0) $display("FAIL clean_stall: got %b want 0", CaptureStall); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (Empty !== 1'b1) $display("FAIL clean_empty: got %b want 1", Empty); else pass_cnt++;
    set_victim(3, 20'h0CAFE, 9'h044, 1'b1, line);
    FlushStage = 1'b1;
    #1;
    total_cnt++; if (CaptureStall !== 1'b0) $display("FAIL flush_stall: got %b want 0", CaptureStall); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (Empty !== 1'b1) $display("FAIL flush_empty: got %b want 1", Empty); else pass_cnt++;
    CaptureReq = 1'b0;
    FlushStage = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_full_and_snoop;
    logic [LL-1:0] line3;
    int base;
    int done;
    WBReady = 1'b0;
    do_capture(2, 20'h12345, 9'h01A);
    do_capture(0, 20'hABCDE, 9'h155);
    LookupAdr = {20'h12345, 9'h01A};
    #1;
    total_cnt++; if (Conflict !== 1'b1) $display("FAIL snoop_match_head: got %b want 1", Conflict); else pass_cnt++;
    LookupAdr = {20'hABCDE, 9'h155};
    #1;
    total_cnt++; if (Conflict !== 1'b1) $display("FAIL snoop_match_second: got %b want 1", Conflict); else pass_cnt++;
    LookupAdr = {20'h54321, 9'h0F1};
    #1;
`ifdef VICTIMBUF_SNOOP_EN
    total_cnt++; if (Conflict !== 1'b0) $display("FAIL snoop_nomatch: got %b want 0", Conflict); else pass_cnt++;
`else
    total_cnt++; if (Conflict !== 1'b1) $display("FAIL snoop_nomatch: got %b want 1", Conflict); else pass_cnt++;
`endif
    set_victim(1, 20'h0F0F0, 9'h0AA, 1'b1, line3);
    CaptureReq = 1'b1;
    #1;
    total_cnt++; if (CaptureStall !== 1'b1) $display("FAIL full_stall: got %b want 1", CaptureStall); else pass_cnt++;
    base = accepted;
    done = 0;
    WBReady = 1'b1;
    for (int i = 0; i < 20 && done == 0; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (CaptureStall !== ((accepted - base) < 4))
        $display("FAIL full_stall_release: got %b want %b after %0d beats", CaptureStall, (accepted - base) < 4, accepted - base);
      else pass_cnt++;
      if ((accepted - base) >= 4) done = 1;
    end
    total_cnt++; if (done == 0) $display("FAIL full_release_timeout: beats %0d want 4", accepted - base); else pass_cnt++;
    @(posedge clk);
    push_expected(20'h0F0F0, 9'h0AA, line3);
    #1 CaptureReq = 1'b0;
    wait_drain(40);
    total_cnt++; if (sb.size() != 0) $display("FAIL full_drain: %0d beats left, want 0", sb.size()); else pass_cnt++;
    total_cnt++; if (Empty !== 1'b1) $display("FAIL full_empty_after: got %b want 1", Empty); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic pat [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    WBReady = 1'b0;
    do_capture(3, 20'h3C3C3, 9'h1F0);
    for (int i = 0; i < 48 && sb.size() != 0; i++) begin
      WBReady = pat[i % 12];
      @(posedge clk); #1;
    end
    WBReady = 1'b1;
    wait_drain(10);
    total_cnt++; if (sb.size() != 0) $display("FAIL bp_drain: %0d beats left, want 0", sb.size()); else pass_cnt++;
    total_cnt++; if (Empty !== 1'b1) $display("FAIL bp_empty_after: got %b want 1", Empty); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    WBReady = 1'b0;
    do_capture(1, 20'h11111, 9'h011);
    do_capture(3, 20'h22222, 9'h022);
    WBReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total_cnt++;
      if (WBValid !== 1'b1) $display("FAIL b2b_no_bubble: cycle %0d valid=%b want 1", i, WBValid);
      else pass_cnt++;
    end
    wait_drain(20);
    total_cnt++; if (sb.size() != 0) $display("FAIL b2b_drain: %0d beats left, want 0", sb.size()); else pass_cnt++;
    total_cnt++; if (WBValid !== 1'b0) $display("FAIL b2b_idle_after: got %b want 0", WBValid); else pass_cnt++;
  endtask

  task automatic test_reset_midburst;
    int base;
    WBReady = 1'b1;
    do_capture(2, 20'h7E7E7, 9'h0C3);
    base = accepted;
    for (int i = 0; i < 20 && (accepted - base) < 2; i++) @(posedge clk);
    total_cnt++; if ((accepted - base) < 2) $display("FAIL midburst_reach: beats %0d want 2", accepted - base); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (WBValid !== 1'b0) $display("FAIL midburst_valid_drop: got %b want 0", WBValid); else pass_cnt++;
    total_cnt++; if (Empty !== 1'b1) $display("FAIL midburst_empty: got %b want 1", Empty); else pass_cnt++;
    sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total_cnt++; if (WBValid !== 1'b0) $display("FAIL midburst_after_valid: got %b want 0", WBValid); else pass_cnt++;
    total_cnt++; if (Empty !== 1'b1) $display("FAIL midburst_after_empty: got %b want 1", Empty); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_dirty_capture;
    test_clean_victim;
    test_full_and_snoop;
    test_backpressure;
    test_back_to_back;
    test_reset_midburst;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
